airlock_sequencer: RTL and testbench

Parametrised airlock interlock sequencer for the lab board; next-generation replacement for the per-port toggle/counter glue in the top level.
- Owns the outer port, the inner port and the chamber pressure state in a single FSM.
- Enforces the interlock rules and times fill/pressurize and evacuate against a tick strobe (e.g. one pulse per second from the clock divider).
- Exposes registered status for LEDR and a countdown for the HEX displays.

---
 rtl/airlock_sequencer.sv | 168 ++++++++++++++++
 tb/tb_airlock_sequencer.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/airlock_sequencer.sv
// Airlock interlock sequencer.
// One FSM owns the chamber pressure state and both port doors. Fill and
// evacuation are timed by counting an external tick strobe. Every output
// comes straight from a flop, so the LEDR/HEX glue sees clean registered
// levels and single-cycle done/reject pulses.
//
// Request semantics: fill_req, evac_req, outer_toggle and inner_toggle are
// single-cycle strobes that arrive already synchronised and edge-detected.
// There is no ready/backpressure. A request is either accepted on the edge
// where it is high, or refused with a one-cycle reject pulse and no state
// change. More than one request in the same cycle is refused as a group
// with a single reject pulse.
module airlock_sequencer #(
  parameter int CNT_W       = 4,
  parameter int PRESS_TICKS = 7,
  parameter int EVAC_TICKS  = 5
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             tick,
  input  logic             outer_toggle,
  input  logic             inner_toggle,
  input  logic             fill_req,
  input  logic             evac_req,
  output logic             outer_open,
  output logic             inner_open,
  output logic             pressurized,
  output logic             evacuated,
  output logic             busy,
  output logic [CNT_W-1:0] remaining,
  output logic             done,
  output logic             reject,
  output logic [1:0]       fsm_state
);

  // Chamber states. The encoding is also visible on fsm_state for debug.
  localparam logic [1:0] ST_EVAC         = 2'd0;
  localparam logic [1:0] ST_PRESSURIZING = 2'd1;
  localparam logic [1:0] ST_PRESS        = 2'd2;
  localparam logic [1:0] ST_EVACUATING   = 2'd3;

  localparam int MAX_TICKS = (1 << CNT_W) - 1;

  // Durations that cannot be loaded into the countdown stop elaboration.
  if (CNT_W < 1 || CNT_W > 16) begin : g_bad_cnt_w
    $fatal(1, "airlock_sequencer: CNT_W must be between 1 and 16");
  end
  if (PRESS_TICKS < 1 || PRESS_TICKS > MAX_TICKS) begin : g_bad_press
    $fatal(1, "airlock_sequencer: PRESS_TICKS must be between 1 and 2^CNT_W-1");
  end
  if (EVAC_TICKS < 1 || EVAC_TICKS > MAX_TICKS) begin : g_bad_evac
    $fatal(1, "airlock_sequencer: EVAC_TICKS must be between 1 and 2^CNT_W-1");
  end

  localparam logic [CNT_W-1:0] PRESS_LOAD = CNT_W'(PRESS_TICKS);
  localparam logic [CNT_W-1:0] EVAC_LOAD  = CNT_W'(EVAC_TICKS);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = '0;

  logic [1:0]       state;
  logic [1:0]       state_n;
  logic [CNT_W-1:0] remaining_n;
  logic             outer_n;
  logic             inner_n;

  logic [2:0] req_count;
  logic       any_req;
  logic       single_req;
  logic       running;
  logic       ports_closed;
  logic       accept_fill;
  logic       accept_evac;
  logic       accept_outer;
  logic       accept_inner;
  logic       refuse;
  logic       count_tick;
  logic       last_tick;

  assign fsm_state = state;

  // Request decode: which single request (if any) the interlock allows.
  always_comb begin
    req_count    = {2'b00, fill_req} + {2'b00, evac_req}
                 + {2'b00, outer_toggle} + {2'b00, inner_toggle};
    any_req      = (req_count != 3'd0);
    single_req   = (req_count == 3'd1);
    running      = (state == ST_PRESSURIZING) || (state == ST_EVACUATING);
    ports_closed = !outer_open && !inner_open;

    // Chamber operations need both doors shut and the matching rest state.
    accept_fill  = single_req && fill_req && (state == ST_EVAC)  && ports_closed;
    accept_evac  = single_req && evac_req && (state == ST_PRESS) && ports_closed;

    // Closing a door is always allowed at rest; opening needs the chamber
    // to match the side of the door and the other door to be shut.
    accept_outer = single_req && outer_toggle && !running &&
                   (outer_open || ((state == ST_EVAC) && !inner_open));
    accept_inner = single_req && inner_toggle && !running &&
                   (inner_open || ((state == ST_PRESS) && !outer_open));

    refuse       = any_req && !(accept_fill || accept_evac ||
                                accept_outer || accept_inner);

    // Ticks only count while an operation is running. The accept cycle is
    // still a rest state, so a tick coincident with it is ignored.
    count_tick   = running && tick && (remaining != CNT_ZERO);
    last_tick    = count_tick && (remaining == CNT_ONE);
  end

  // Next chamber state.
  always_comb begin
    state_n = state;
    case (state)
      ST_EVAC:         if (accept_fill) state_n = ST_PRESSURIZING;
      ST_PRESSURIZING: if (last_tick)   state_n = ST_PRESS;
      ST_PRESS:        if (accept_evac) state_n = ST_EVACUATING;
      ST_EVACUATING:   if (last_tick)   state_n = ST_EVAC;
      default:         state_n = ST_EVAC;
    endcase
  end

  // Next countdown value: load on accept, step down on each counted tick.
  always_comb begin
    remaining_n = remaining;
    if (accept_fill) begin
      remaining_n = PRESS_LOAD;
    end else if (accept_evac) begin
      remaining_n = EVAC_LOAD;
    end else if (count_tick) begin
      remaining_n = remaining - CNT_ONE;
    end
  end

  // Next door positions: an accepted toggle flips the door.
  always_comb begin
    outer_n = outer_open;
    inner_n = inner_open;
    if (accept_outer) outer_n = !outer_open;
    if (accept_inner) inner_n = !inner_open;
  end

  // State and status registers; status is derived from the next state so
  // it lines up with the state register on the same edge.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state       <= ST_EVAC;
      remaining   <= CNT_ZERO;
      outer_open  <= 1'b0;
      inner_open  <= 1'b0;
      pressurized <= 1'b0;
      evacuated   <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      reject      <= 1'b0;
    end else begin
      state       <= state_n;
      remaining   <= remaining_n;
      outer_open  <= outer_n;
      inner_open  <= inner_n;
      pressurized <= (state_n == ST_PRESS);
      evacuated   <= (state_n == ST_EVAC);
      busy        <= (state_n == ST_PRESSURIZING) || (state_n == ST_EVACUATING);
      done        <= last_tick;
      reject      <= refuse;
    end
  end

endmodule

// File: tb/tb_airlock_sequencer.sv
// Bench for airlock_sequencer: a directed vector table plus hand-written
// reset/parameter sequences on a default instance and a CNT_W=3 instance,
// then a randomized run of both against a rule-level reference model.
module tb_airlock_sequencer;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT A: default parameters ----------------
  logic       a_rst, a_tick, a_ot, a_it, a_fr, a_er;
  logic       a_oo, a_io, a_pr, a_ev, a_bz, a_dn, a_rj;
  logic [3:0] a_rem;
  logic [1:0] a_st;

  airlock_sequencer #(.CNT_W(4), .PRESS_TICKS(7), .EVAC_TICKS(5)) dut_a (
    .Clock(clk), .Reset(a_rst), .tick(a_tick),
    .outer_toggle(a_ot), .inner_toggle(a_it), .fill_req(a_fr), .evac_req(a_er),
    .outer_open(a_oo), .inner_open(a_io), .pressurized(a_pr), .evacuated(a_ev),
    .busy(a_bz), .remaining(a_rem), .done(a_dn), .reject(a_rj), .fsm_state(a_st)
  );

  // ---------------- DUT B: parameter sweep ----------------
  logic       b_rst, b_tick, b_ot, b_it, b_fr, b_er;
  logic       b_oo, b_io, b_pr, b_ev, b_bz, b_dn, b_rj;
  logic [2:0] b_rem;
  logic [1:0] b_st;

  airlock_sequencer #(.CNT_W(3), .PRESS_TICKS(1), .EVAC_TICKS(7)) dut_b (
    .Clock(clk), .Reset(b_rst), .tick(b_tick),
    .outer_toggle(b_ot), .inner_toggle(b_it), .fill_req(b_fr), .evac_req(b_er),
    .outer_open(b_oo), .inner_open(b_io), .pressurized(b_pr), .evacuated(b_ev),
    .busy(b_bz), .remaining(b_rem), .done(b_dn), .reject(b_rj), .fsm_state(b_st)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  // Output bundle: {outer, inner, pressurized, evacuated, busy, remaining[3:0], done, reject}
  function automatic logic [10:0] pk(input logic oo, io, pr, ev, bz,
                                     input logic [3:0] rem, input logic dn, rj);
    return {oo, io, pr, ev, bz, rem, dn, rj};
  endfunction

  function automatic logic [10:0] act_a();
    return pk(a_oo, a_io, a_pr, a_ev, a_bz, a_rem, a_dn, a_rj);
  endfunction

  function automatic logic [10:0] act_b();
    return pk(b_oo, b_io, b_pr, b_ev, b_bz, {1'b0, b_rem}, b_dn, b_rj);
  endfunction

  task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%b expected=%b (oo io pr ev bz rem[4] dn rj)", name, act, exp);
    end
  endtask

  task automatic check_interlock(input string name, input logic oo, io, pr, ev, bz);
    logic [2:0] bad;
    bad = {oo & io, (oo | io) & bz, pr & ev};
    checks++;
    if (bad !== 3'b000) begin
      errors++;
      $display("FAIL %s violation=%b expected=000 (both_open, open_while_busy, press_and_evac)", name, bad);
    end
  endtask

  // ---------------- driver tasks ----------------
  // in = {tick, outer_toggle, inner_toggle, fill_req, evac_req}
  task automatic apply_a(input logic [4:0] in);
    @(negedge clk);
    {a_tick, a_ot, a_it, a_fr, a_er} = in;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_b(input logic [4:0] in);
    @(negedge clk);
    {b_tick, b_ot, b_it, b_fr, b_er} = in;
    @(posedge clk);
    #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [4:0]  in;
    logic [10:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic t, ot, it, fr, er,
                              input logic oo, io, pr, ev, bz,
                              input int rem, input logic dn, rj);
    vec_t v;
    v.in  = {t, ot, it, fr, er};
    v.exp = pk(oo, io, pr, ev, bz, 4'(rem), dn, rj);
    return v;
  endfunction

  // ---------------- reference model ----------------
  // Chamber described by where it rests, the operation under way and how
  // many ticks of it are left.
  typedef struct {
    bit at_pressure;
    bit filling;
    bit outer;
    bit inner;
    bit done;
    bit reject;
    int left;
  } mdl_t;

  function automatic mdl_t mdl_reset();
    mdl_t m;
    m.at_pressure = 0; m.filling = 0; m.outer = 0; m.inner = 0;
    m.done = 0; m.reject = 0; m.left = 0;
    return m;
  endfunction

  function automatic mdl_t mdl_step(input mdl_t m_in, input logic [4:0] in,
                                    input int press_ticks, input int evac_ticks);
    mdl_t m;
    bit tk, ot, it, fr, er, shut;
    int nreq;
    m = m_in;
    {tk, ot, it, fr, er} = in;
    nreq = int'(ot) + int'(it) + int'(fr) + int'(er);
    shut = !m.outer && !m.inner;
    m.done = 0;
    m.reject = 0;
    if (m.left > 0) begin
      if (nreq > 0) m.reject = 1;
      if (tk) begin
        m.left = m.left - 1;
        if (m.left == 0) begin
          m.at_pressure = m.filling;
          m.done = 1;
        end
      end
    end else if (nreq > 1) begin
      m.reject = 1;
    end else if (fr) begin
      if (!m.at_pressure && shut) begin m.left = press_ticks; m.filling = 1; end
      else m.reject = 1;
    end else if (er) begin
      if (m.at_pressure && shut) begin m.left = evac_ticks; m.filling = 0; end
      else m.reject = 1;
    end else if (ot) begin
      if (m.outer) m.outer = 0;
      else if (!m.at_pressure && !m.inner) m.outer = 1;
      else m.reject = 1;
    end else if (it) begin
      if (m.inner) m.inner = 0;
      else if (m.at_pressure && !m.outer) m.inner = 1;
      else m.reject = 1;
    end
    return m;
  endfunction

  function automatic logic [10:0] exp_of(input mdl_t m);
    bit bz;
    bz = (m.left > 0);
    return pk(m.outer, m.inner, !bz && m.at_pressure, !bz && !m.at_pressure,
              bz, 4'(m.left), m.done, m.reject);
  endfunction

  function automatic logic [4:0] rand_in();
    logic t;
    int r;
    logic [3:0] req;   // {outer, inner, fill, evac}
    t = 1'($urandom_range(0, 1));
    r = $urandom_range(0, 15);
    case (r)
      8:       req = 4'b1000;
      9:       req = 4'b0100;
      10, 12:  req = 4'b0010;
      11, 13:  req = 4'b0001;
      14:      req = 4'b1010;
      15:      req = 4'b0101;
      default: req = 4'b0000;
    endcase
    return {t, req};
  endfunction

  // ---------------- stimulus ----------------
  mdl_t ma, mb;

  initial begin
    // Directed table for DUT A (P=7, E=5), starting from reset.
    vecs.push_back(mk(1,0,0,1,0, 0,0,0,0,1,7,0,0)); // fill, coincident tick ignored
    vecs.push_back(mk(1,0,0,0,0, 0,0,0,0,1,6,0,0));
    vecs.push_back(mk(0,0,0,0,0, 0,0,0,0,1,6,0,0)); // no tick, holds
    for (int k = 5; k >= 1; k--) vecs.push_back(mk(1,0,0,0,0, 0,0,0,0,1,k,0,0));
    vecs.push_back(mk(1,0,0,0,0, 0,0,1,0,0,0,1,0)); // 7th tick: pressurized, done
    vecs.push_back(mk(0,0,0,0,0, 0,0,1,0,0,0,0,0)); // done lasts one cycle
    vecs.push_back(mk(0,1,0,0,0, 0,0,1,0,0,0,0,1)); // outer open in PRESS refused
    vecs.push_back(mk(0,0,1,0,0, 0,1,1,0,0,0,0,0)); // inner opens
    vecs.push_back(mk(0,0,0,0,1, 0,1,1,0,0,0,0,1)); // evac with inner open refused
    vecs.push_back(mk(0,1,0,0,0, 0,1,1,0,0,0,0,1)); // outer while inner open refused
    vecs.push_back(mk(0,0,1,0,0, 0,0,1,0,0,0,0,0)); // inner closes
    vecs.push_back(mk(1,0,0,0,1, 0,0,0,0,1,5,0,0)); // evac accepted, tick ignored
    vecs.push_back(mk(0,0,0,1,0, 0,0,0,0,1,5,0,1)); // request while busy refused
    vecs.push_back(mk(1,0,1,0,0, 0,0,0,0,1,4,0,1)); // refused, tick still counts
    for (int k = 3; k >= 1; k--) vecs.push_back(mk(1,0,0,0,0, 0,0,0,0,1,k,0,0));
    vecs.push_back(mk(1,0,0,0,0, 0,0,0,1,0,0,1,0)); // evacuated, done
    vecs.push_back(mk(0,0,0,0,0, 0,0,0,1,0,0,0,0));
    vecs.push_back(mk(0,1,0,0,0, 1,0,0,1,0,0,0,0)); // outer opens in EVAC
    vecs.push_back(mk(0,0,0,1,0, 1,0,0,1,0,0,0,1)); // fill with outer open refused
    vecs.push_back(mk(0,0,1,0,0, 1,0,0,1,0,0,0,1)); // inner open in EVAC refused
    vecs.push_back(mk(1,1,0,0,0, 0,0,0,1,0,0,0,0)); // outer closes, idle tick no effect
    vecs.push_back(mk(0,1,0,1,0, 0,0,0,1,0,0,0,1)); // simultaneous: single reject
    vecs.push_back(mk(0,0,0,0,1, 0,0,0,1,0,0,0,1)); // evac in EVAC refused
    vecs.push_back(mk(0,0,1,0,0, 0,0,0,1,0,0,0,1)); // inner open in EVAC refused
    vecs.push_back(mk(0,0,0,1,0, 0,0,0,0,1,7,0,0)); // fill accepted
    for (int k = 6; k >= 3; k--) vecs.push_back(mk(1,0,0,0,0, 0,0,0,0,1,k,0,0));

    // Reset both instances.
    a_rst = 1'b1; b_rst = 1'b1;
    {a_tick, a_ot, a_it, a_fr, a_er} = '0;
    {b_tick, b_ot, b_it, b_fr, b_er} = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_a", act_a(), pk(0,0,0,1,0,4'd0,0,0));
    check("reset_b", act_b(), pk(0,0,0,1,0,4'd0,0,0));
    @(negedge clk);
    a_rst = 1'b0; b_rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      apply_a(vecs[i].in);
      check($sformatf("vec%0d", i), act_a(), vecs[i].exp);
    end

    // Reset while PRESSURIZING with remaining=3: abort, no done pulse.
    @(negedge clk);
    a_rst = 1'b1;
    {a_tick, a_ot, a_it, a_fr, a_er} = 5'b10000;
    @(posedge clk);
    #1;
    check("reset_abort", act_a(), pk(0,0,0,1,0,4'd0,0,0));
    @(negedge clk);
    a_rst = 1'b0;
    a_tick = 1'b0;
    @(posedge clk);
    #1;
    check("reset_no_done", act_a(), pk(0,0,0,1,0,4'd0,0,0));

    // Parameter sweep instance: 1-tick fill, 7-tick evacuation.
    apply_b(5'b00010);
    check("b_fill_accept", act_b(), pk(0,0,0,0,1,4'd1,0,0));
    apply_b(5'b10000);
    check("b_fill_done", act_b(), pk(0,0,1,0,0,4'd0,1,0));
    apply_b(5'b10001);
    check("b_evac_accept", act_b(), pk(0,0,0,0,1,4'd7,0,0));
    for (int k = 6; k >= 1; k--) begin
      apply_b(5'b10000);
      check($sformatf("b_evac_rem%0d", k), act_b(), pk(0,0,0,0,1,4'(k),0,0));
    end
    apply_b(5'b10000);
    check("b_evac_done", act_b(), pk(0,0,0,1,0,4'd0,1,0));
    apply_b(5'b00000);
    check("b_evac_idle", act_b(), pk(0,0,0,1,0,4'd0,0,0));

    // Randomized run of both instances against the reference model.
    @(negedge clk);
    a_rst = 1'b1; b_rst = 1'b1;
    {a_tick, a_ot, a_it, a_fr, a_er} = '0;
    {b_tick, b_ot, b_it, b_fr, b_er} = '0;
    @(posedge clk);
    ma = mdl_reset();
    mb = mdl_reset();
    for (int c = 0; c < 3000; c++) begin
      logic [4:0] ia, ib;
      @(negedge clk);
      ia = rand_in();
      ib = rand_in();
      a_rst = ($urandom_range(0, 199) == 0);
      b_rst = ($urandom_range(0, 199) == 0);
      {a_tick, a_ot, a_it, a_fr, a_er} = ia;
      {b_tick, b_ot, b_it, b_fr, b_er} = ib;
      ma = a_rst ? mdl_reset() : mdl_step(ma, ia, 7, 5);
      mb = b_rst ? mdl_reset() : mdl_step(mb, ib, 1, 7);
      @(posedge clk);
      #1;
      check($sformatf("rand_a_c%0d", c), act_a(), exp_of(ma));
      check($sformatf("rand_b_c%0d", c), act_b(), exp_of(mb));
      check_interlock($sformatf("interlock_a_c%0d", c), a_oo, a_io, a_pr, a_ev, a_bz);
      check_interlock($sformatf("interlock_b_c%0d", c), b_oo, b_io, b_pr, b_ev, b_bz);
    end

    // ---------------- final report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
